// File: rtl/branch_pkg.sv
// Shared types and condition-index constants for the branch condition controller.
package branch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_FLAGS,
      RESOLVE,
      FLUSH
   } state_e;

   localparam logic [3:0] COND_ALWAYS     = 4'd11;
   localparam logic [3:0] COND_NEVER      = 4'd10;
   localparam logic [3:0] COND_LAST_LEGAL = 4'd11;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch condition test against the 12-bit comparison-flag register.
module cond_eval
   import branch_pkg::*;
(
   input  logic [3:0]  cond_i,
   input  logic        negate_i,
   input  logic [11:0] comp_reg_i,
   output logic        taken_o
);

   logic [15:0] flags_ext;

   // Indices past the flag register are never taken, whatever the negate bit says.
   always_comb begin
      flags_ext = {4'b0000, comp_reg_i};
      taken_o   = 1'b0;
      if (cond_i <= COND_LAST_LEGAL) begin
         taken_o = flags_ext[cond_i] ^ negate_i;
      end
   end

endmodule

// File: rtl/branch_cond_ctrl.sv
// Branch condition sequencer: flag interlock, resolve, redirect and fixed flush.
// Optional taken/not-taken statistics counters under BRANCH_STATS_EN.
module branch_cond_ctrl
   import branch_pkg::*;
#(
   parameter int PC_W         = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_br_valid,
   output logic            o_br_ready,
   input  logic [3:0]      i_br_cond,
   input  logic            i_br_negate,
   input  logic [PC_W-1:0] i_br_target,
   input  logic            i_cmp_pending,
   input  logic [11:0]     i_comp_reg,
   output logic            o_stall,
   output logic            o_redirect_valid,
   output logic [PC_W-1:0] o_redirect_pc,
   output logic            o_flush
`ifdef BRANCH_STATS_EN
  ,output logic [15:0]     o_taken_cnt,
   output logic [15:0]     o_nottaken_cnt
`endif
);

   localparam logic [3:0] FLUSH_LOAD = FLUSH_CYCLES[3:0];

   state_e          state_q;
   logic [3:0]      cond_q;
   logic            negate_q;
   logic [PC_W-1:0] target_q;
   logic [PC_W-1:0] pc_q;
   logic [3:0]      cnt_q;
   logic            taken;

   cond_eval u_cond_eval (
      .cond_i     (cond_q),
      .negate_i   (negate_q),
      .comp_reg_i (i_comp_reg),
      .taken_o    (taken)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cond_q   <= '0;
         negate_q <= 1'b0;
         target_q <= '0;
         pc_q     <= '0;
         cnt_q    <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (i_br_valid) begin
                  cond_q   <= i_br_cond;
                  negate_q <= i_br_negate;
                  target_q <= i_br_target;
                  state_q  <= i_cmp_pending ? WAIT_FLAGS : RESOLVE;
               end
            end
            WAIT_FLAGS: begin
               if (!i_cmp_pending) begin
                  state_q <= RESOLVE;
               end
            end
            RESOLVE: begin
               if (taken) begin
                  pc_q    <= target_q;
                  cnt_q   <= FLUSH_LOAD;
                  state_q <= FLUSH;
               end else begin
                  state_q <= IDLE;
               end
            end
            FLUSH: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // pc_q keeps the last redirect so the PC output is stable between strobes.
   always_comb begin
      o_br_ready       = (state_q == IDLE);
      o_stall          = (state_q == WAIT_FLAGS) || (state_q == RESOLVE);
      o_redirect_valid = (state_q == RESOLVE) && taken;
      o_redirect_pc    = o_redirect_valid ? target_q : pc_q;
      o_flush          = (state_q == FLUSH);
   end

`ifdef BRANCH_STATS_EN
   logic [15:0] taken_cnt_q;
   logic [15:0] taken_cnt_d;
   logic [15:0] nottaken_cnt_q;
   logic [15:0] nottaken_cnt_d;

   always_comb begin
      taken_cnt_d    = taken_cnt_q;
      nottaken_cnt_d = nottaken_cnt_q;
      if (state_q == RESOLVE) begin
         if (taken && taken_cnt_q != 16'hFFFF) begin
            taken_cnt_d = taken_cnt_q + 16'd1;
         end
         if (!taken && nottaken_cnt_q != 16'hFFFF) begin
            nottaken_cnt_d = nottaken_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         taken_cnt_q    <= '0;
         nottaken_cnt_q <= '0;
      end else begin
         taken_cnt_q    <= taken_cnt_d;
         nottaken_cnt_q <= nottaken_cnt_d;
      end
   end

   assign o_taken_cnt    = taken_cnt_q;
   assign o_nottaken_cnt = nottaken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_cond_ctrl.sv
// Self-checking bench for branch_cond_ctrl: per-cycle timeline model plus literal pins.
// Stats counters are also checked when BRANCH_STATS_EN is defined.
module tb_branch_cond_ctrl;

   localparam int PC_W = 32;
   localparam int FC   = 2;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            br_valid = 1'b0;
   logic            br_ready;
   logic [3:0]      br_cond = 4'd0;
   logic            br_negate = 1'b0;
   logic [PC_W-1:0] br_target = '0;
   logic            cmp_pending = 1'b0;
   logic [11:0]     comp_reg = 12'h800;
   logic            stall;
   logic            redir_v;
   logic [PC_W-1:0] redir_pc;
   logic            flush;
`ifdef BRANCH_STATS_EN
   logic [15:0]     taken_cnt;
   logic [15:0]     nottaken_cnt;
`endif

   branch_cond_ctrl #(.PC_W(PC_W), .FLUSH_CYCLES(FC)) dut (
      .clk              (clk),
      .reset            (reset),
      .i_br_valid       (br_valid),
      .o_br_ready       (br_ready),
      .i_br_cond        (br_cond),
      .i_br_negate      (br_negate),
      .i_br_target      (br_target),
      .i_cmp_pending    (cmp_pending),
      .i_comp_reg       (comp_reg),
      .o_stall          (stall),
      .o_redirect_valid (redir_v),
      .o_redirect_pc    (redir_pc),
      .o_flush          (flush)
`ifdef BRANCH_STATS_EN
     ,.o_taken_cnt      (taken_cnt),
      .o_nottaken_cnt   (nottaken_cnt)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic            e_ready = 1'b1;
   logic            e_stall = 1'b0;
   logic            e_rv = 1'b0;
   logic [PC_W-1:0] e_pc = '0;
   logic            e_flush = 1'b0;
   logic [PC_W-1:0] last_pc = '0;
   logic [15:0]     mt = '0;
   logic [15:0]     mn = '0;

   logic [PC_W-1:0] seen_pc = '0;
   int n_redir = 0;
   int n_flush = 0;
   int n_busy = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void set_exp(logic r, logic s, logic v,
                                   logic [PC_W-1:0] pc, logic f);
      e_ready = r;
      e_stall = s;
      e_rv    = v;
      e_pc    = pc;
      e_flush = f;
   endfunction

   function automatic logic [15:0] sat(logic [15:0] x);
      return (x == 16'hFFFF) ? x : x + 16'd1;
   endfunction

   always @(negedge clk) begin
      chk("ready", br_ready, e_ready);
      chk("stall", stall, e_stall);
      chk("redirect_valid", redir_v, e_rv);
      chk("redirect_pc", redir_pc, e_pc);
      chk("flush", flush, e_flush);
`ifdef BRANCH_STATS_EN
      chk("taken_cnt", taken_cnt, mt);
      chk("nottaken_cnt", nottaken_cnt, mn);
`endif
      if (redir_v) begin
         seen_pc = redir_pc;
         n_redir++;
      end
      if (flush) n_flush++;
      if (!br_ready) n_busy++;
   end

   // One branch: request cycle, pend wait cycles, resolve, flush, back to idle.
   // rst_at > 0 pulses reset in that flush cycle instead of finishing the flush.
   task automatic branch(input logic [3:0] c, input logic n,
                         input logic [PC_W-1:0] t, input logic [11:0] comp0,
                         input logic [11:0] comp1, input int pend,
                         input int rst_at);
      bit tk;
      bit aborted;
      aborted = 0;
      @(posedge clk); #1;
      n_redir = 0;
      n_flush = 0;
      n_busy  = 0;
      br_valid    = 1'b1;
      br_cond     = c;
      br_negate   = n;
      br_target   = t;
      comp_reg    = comp0;
      cmp_pending = (pend > 0);
      set_exp(1, 0, 0, last_pc, 0);
      for (int k = 1; k < pend; k++) begin
         @(posedge clk); #1;
         br_valid  = 1'b0;
         br_target = ~t;
         set_exp(0, 1, 0, last_pc, 0);
      end
      if (pend > 0) begin
         @(posedge clk); #1;
         br_valid    = 1'b0;
         cmp_pending = 1'b0;
         comp_reg    = comp1;
         set_exp(0, 1, 0, last_pc, 0);
      end
      @(posedge clk); #1;
      br_valid    = 1'b0;
      br_target   = ~t;
      br_cond     = ~c;
      comp_reg    = comp1;
      cmp_pending = 1'b1;
      tk = (c <= 4'd11) ? (comp1[c] ^ n) : 1'b0;
      set_exp(0, 1, tk, tk ? t : last_pc, 0);
      if (tk) last_pc = t;
      if (tk) begin
         for (int f = 1; f <= FC; f++) begin
            @(posedge clk); #1;
            if (f == 1) mt = sat(mt);
            if (f == rst_at) begin
               reset   = 1'b1;
               last_pc = '0;
               mt      = '0;
               mn      = '0;
               set_exp(1, 0, 0, '0, 0);
               aborted = 1;
               break;
            end
            set_exp(0, 0, 0, last_pc, 1);
         end
      end
      @(posedge clk); #1;
      if (!tk) mn = sat(mn);
      if (aborted) reset = 1'b0;
      cmp_pending = 1'b0;
      set_exp(1, 0, 0, last_pc, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      branch(4'd11, 1'b0, 32'h0000_0100, 12'h800, 12'h800, 0, 0);
      chk("always_pc_lit", seen_pc, 32'h0000_0100);
      chk("always_redir_lit", n_redir, 1);
      chk("always_flush_lit", n_flush, 2);
      chk("always_busy_lit", n_busy, 3);

      branch(4'd0, 1'b1, 32'h0000_0200, 12'h801, 12'h801, 0, 0);
      chk("neg_redir_lit", n_redir, 0);
      chk("neg_flush_lit", n_flush, 0);
      chk("neg_busy_lit", n_busy, 1);

      branch(4'd3, 1'b0, 32'h0000_0300, 12'h800, 12'h808, 3, 0);
      chk("pend_pc_lit", seen_pc, 32'h0000_0300);
      chk("pend_busy_lit", n_busy, 6);

      branch(4'd13, 1'b1, 32'h0000_0400, 12'hFFF, 12'hFFF, 0, 0);
      chk("oob_redir_lit", n_redir, 0);
      branch(4'd10, 1'b1, 32'h0000_0500, 12'h800, 12'h800, 0, 0);
      chk("never_neg_pc_lit", seen_pc, 32'h0000_0500);

      branch(4'd11, 1'b0, 32'h0000_0600, 12'h800, 12'h800, 0, 2);
      chk("rst_flush_lit", n_flush, 1);

      branch(4'd5, 1'b0, 32'h0000_0700, 12'h020, 12'h020, 0, 0);
      chk("post_rst_pc_lit", seen_pc, 32'h0000_0700);
      branch(4'd5, 1'b1, 32'h0000_0710, 12'h020, 12'h020, 0, 0);
      branch(4'd0, 1'b0, 32'h0000_0720, 12'h800, 12'h800, 0, 0);
      branch(4'd11, 1'b0, 32'h0000_0730, 12'h800, 12'h800, 0, 0);
      branch(4'd2, 1'b1, 32'h0000_0740, 12'h800, 12'h800, 0, 0);
      chk("last_pc_lit", seen_pc, 32'h0000_0740);

`ifdef BRANCH_STATS_EN
      chk("taken_cnt_lit", taken_cnt, 16'd3);
      chk("nottaken_cnt_lit", nottaken_cnt, 16'd2);
      @(posedge clk); #1;
      force dut.taken_cnt_q = 16'hFFFF;
      mt = 16'hFFFF;
      @(posedge clk); #1;
      release dut.taken_cnt_q;
      branch(4'd11, 1'b0, 32'h0000_0800, 12'h800, 12'h800, 0, 0);
      chk("taken_sat_lit", taken_cnt, 16'hFFFF);
`endif

      repeat (2) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/branch_cond_ctrl.md
Name: branch_cond_ctrl

Overview:
- Sequences conditional branches against the 12-bit comparison-flag register.
- Flag register layout: bit 11 is Always (1), bit 10 is Never (0), bits 9-0 are ALU compare flags, written on CMP.
- Accepts one branch request at a time. Interlocks on an in-flight CMP, resolves the condition, and on a taken branch issues a PC redirect followed by a fixed-length pipeline flush.
- Sits between decode and the fetch/PC unit, beside the comparison-flag register.

Parameters:
- PC_W, 32, width of branch target and redirect PC.
- FLUSH_CYCLES, 2, cycles o_flush is held after a taken branch (legal range 1-15).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- i_br_valid  in  1  branch request valid.
- o_br_ready  out  1  controller can accept a request.
- i_br_cond  in  4  index of comparison-flag bit to test (0-11 legal).
- i_br_negate  in  1  invert condition result.
- i_br_target  in  PC_W  branch target PC.
- i_cmp_pending  in  1  a CMP is issued but its flags are not yet written.
- i_comp_reg  in  12  current comparison-flag register value.
- o_stall  out  1  hold decode (waiting on flags).
- o_redirect_valid  out  1  one-cycle redirect strobe.
- o_redirect_pc  out  PC_W  redirect target, valid with strobe.
- o_flush  out  1  squash younger instructions.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. Asserting reset, including mid-operation, forces IDLE immediately and clears all captured registers and the flush counter.
- Reset values: o_br_ready=1 (IDLE); o_stall=0; o_redirect_valid=0; o_redirect_pc=0; o_flush=0.
- Handshake:
  - Transfer occurs on a rising edge with i_br_valid & o_br_ready.
  - Cond, negate and target are captured on that edge.
  - o_br_ready=1 only in IDLE.
- FSM states: IDLE, WAIT_FLAGS, RESOLVE, FLUSH.
  - IDLE: on transfer, go to WAIT_FLAGS if i_cmp_pending=1 in that cycle, else to RESOLVE.
  - WAIT_FLAGS: o_stall=1. Stay while i_cmp_pending=1. When i_cmp_pending=0, go to RESOLVE on the next edge, so the updated flags are visible.
  - RESOLVE: taken = (cond<=11) ? (i_comp_reg[cond] ^ negate) : 0.
    - cond 12-15 is never taken, regardless of negate.
    - If taken: o_redirect_valid=1 and o_redirect_pc=target this cycle; load flush counter with FLUSH_CYCLES; go to FLUSH.
    - If not taken: go to IDLE; no outputs asserted.
    - o_stall=1 in RESOLVE.
  - FLUSH: o_flush=1. Decrement the counter each cycle; go to IDLE when it reaches 1. A new request cannot be accepted during FLUSH.
- Outputs are decoded from state plus captured registers, and are glitch-free relative to clk.
- o_redirect_pc holds its last value when the strobe is low.
- Latency with request accepted at edge N and no pending CMP:
  - RESOLVE (and redirect) during cycle N..N+1.
  - o_flush high for the FLUSH_CYCLES cycles that follow.
  - o_br_ready high again FLUSH_CYCLES+1 edges after N.
  - A not-taken branch returns ready after 1 cycle.
- Cond 11 (Always) is always taken and cond 10 (Never) is never taken, matching the register's reset pattern 12'h800.
- i_cmp_pending rising during RESOLVE or FLUSH is ignored; the branch already resolved.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, add two outputs:
  - o_taken_cnt[15:0]: increments on each taken RESOLVE.
  - o_nottaken_cnt[15:0]: increments on each not-taken RESOLVE.
- Both counters saturate at 16'hFFFF and are cleared by reset.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package branch_pkg holds:
  - state enum (IDLE, WAIT_FLAGS, RESOLVE, FLUSH);
  - COND_ALWAYS=4'd11 and COND_NEVER=4'd10;
  - COND_LAST_LEGAL=4'd11.
- Sub-module cond_eval (combinational): inputs cond, negate, comp_reg; output taken, including the out-of-range rule.
- Flush counter and FSM stay in the top.

Test Plan:
- Reset then request cond=11, negate=0, target=32'h0000_0100, no pending -> redirect strobe one cycle with pc 0x100; o_flush high 2 cycles; ready after 3 edges.
- i_comp_reg=12'h801, cond=0, negate=1 -> not taken; no redirect, no flush; ready next cycle.
- i_cmp_pending=1 for 3 cycles while cond=3 request arrives; i_comp_reg bit3 becomes 1 when pending drops -> o_stall high through wait and RESOLVE; redirect taken using the new flags.
- cond=13, negate=1 -> not taken; cond=10, negate=1 -> taken.
- Assert reset during FLUSH (counter=1) -> o_flush=0 immediately; o_br_ready=1 after release; the next request is handled normally.
- BRANCH_STATS_EN: 3 taken and 2 not-taken branches -> o_taken_cnt=3, o_nottaken_cnt=2; force 16'hFFFF, one more taken -> counter stays 16'hFFFF.
